// File: rtl/prog_sequencer_pkg.sv
// Shared types and default widths for the program sequencer slice.
package prog_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    JFETCH = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

  localparam int DEF_PC_W  = 10;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/prog_sequencer_if.sv
// Control/flag bundle between the processor side (master) and the sequencer (slave).
interface prog_sequencer_if
  import prog_sequencer_pkg::*;
#(
  parameter int PC_W     = DEF_PC_W,
  parameter int NUM_PROG = 4,
  parameter int CNT_W    = DEF_CNT_W
) ();
  localparam int SEL_W = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1;

  // Run handshake: req is a level held by the master; the sequencer starts on req=1 in IDLE,
  // raises ack in DONE and holds it until req falls, then returns to IDLE.
  logic              req;
  logic [SEL_W-1:0]  prog_sel;
  logic              stall;
  logic              halt;
  logic              jump_en;
  logic              call_en;
  logic              ret_en;
  logic              branch_taken;
  logic              branch_skip;
  logic [PC_W-1:0]   br_off;
  logic [PC_W-1:0]   jump_addr;
  logic [PC_W-1:0]   pc;
  logic              read_jump;
  logic              busy;
  logic              ack;
  logic              fault;
  logic [CNT_W-1:0]  cycle_cnt;
  seq_state_e        dbg_state;

  modport master (
    output req, prog_sel, stall, halt, jump_en, call_en, ret_en,
           branch_taken, branch_skip, br_off, jump_addr,
    input  pc, read_jump, busy, ack, fault, cycle_cnt, dbg_state
  );

  modport slave (
    input  req, prog_sel, stall, halt, jump_en, call_en, ret_en,
           branch_taken, branch_skip, br_off, jump_addr,
    output pc, read_jump, busy, ack, fault, cycle_cnt, dbg_state
  );
endinterface

// File: rtl/prog_sequencer_ret_stack.sv
// Return-address LIFO; push is dropped when full, pop is dropped when empty.
module prog_sequencer_ret_stack #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clr,
  input  logic [W-1:0] push_data,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] top
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] cnt;
  logic [IW-1:0] top_idx;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign top_idx = IW'(cnt - CW'(1));
  assign top     = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (push && !full) begin
      mem[IW'(cnt)] <= push_data;
      cnt           <= cnt + CW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: run FSM, next-pc mux, return stack and saturating run-cycle counter.
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int                      PC_W        = DEF_PC_W,
  parameter int                      NUM_PROG    = 4,
  parameter logic [NUM_PROG*PC_W-1:0] START_VECS = '0,
  parameter int                      STACK_DEPTH = 4,
  parameter int                      CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  prog_sequencer_if.slave   sif
);
  localparam int SEL_W = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1;

  seq_state_e       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d, start_pc;
  logic [CNT_W-1:0] cnt_q;
  logic             fault_q, fault_d;
  logic             push, pop, clr, full, empty;
  logic [PC_W-1:0]  top;

  // Out-of-range selections fall through to program 0.
  always_comb begin
    start_pc = START_VECS[PC_W-1:0];
    for (int k = 1; k < NUM_PROG; k++)
      if (sif.prog_sel == SEL_W'(k)) start_pc = START_VECS[k*PC_W +: PC_W];
  end

  prog_sequencer_ret_stack #(.W(PC_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .clr       (clr),
    .push_data (pc_q + PC_W'(2)),
    .full      (full),
    .empty     (empty),
    .top       (top)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: if (sif.req) begin
        state_d = RUN;
        pc_d    = start_pc;
        fault_d = 1'b0;
        clr     = 1'b1;
      end
      RUN: begin
        if (sif.stall) begin
          state_d = RUN;
        end else if (sif.halt) begin
          state_d = DONE;
        end else if (sif.ret_en) begin
          if (empty) begin
            fault_d = 1'b1;
            state_d = DONE;
          end else begin
            pc_d = top;
            pop  = 1'b1;
          end
        end else if (sif.call_en) begin
          if (full) begin
            fault_d = 1'b1;
            state_d = DONE;
          end else begin
            push    = 1'b1;
            pc_d    = pc_q + PC_W'(1);
            state_d = JFETCH;
          end
        end else if (sif.jump_en) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = JFETCH;
        end else if (sif.branch_taken) begin
          pc_d = pc_q + sif.br_off;
        end else if (sif.branch_skip) begin
          pc_d = pc_q + PC_W'(2);
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      JFETCH: if (!sif.stall) begin
        pc_d    = sif.jump_addr;
        state_d = RUN;
      end
      DONE: if (!sif.req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      if (state_q == IDLE && sif.req)
        cnt_q <= '0;
      else if ((state_q == RUN || state_q == JFETCH) && !(&cnt_q))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign sif.pc        = pc_q;
  assign sif.read_jump = (state_q == JFETCH);
  assign sif.busy      = (state_q == RUN) || (state_q == JFETCH);
  assign sif.ack       = (state_q == DONE);
  assign sif.fault     = fault_q;
  assign sif.cycle_cnt = cnt_q;
  assign sif.dbg_state = state_q;
endmodule

// File: tb/tb_prog_sequencer.sv
// Directed, table-driven bench for prog_sequencer (PC_W=10, 3 programs, 2-deep stack, 4-bit counter).
module tb_prog_sequencer;
  localparam int PC_W  = 10;
  localparam int NPROG = 3;
  localparam int CNT_W = 4;
  localparam logic [NPROG*PC_W-1:0] VECS = {10'h3FE, 10'h040, 10'h010};

  localparam logic [6:0] N = 7'b0000000, S = 7'b1000000, H = 7'b0100000, R = 7'b0010000,
                         C = 7'b0001000, J = 7'b0000100, B = 7'b0000010, K = 7'b0000001;
  // expected output code: {read_jump, busy, ack, fault}
  localparam logic [3:0] O_ID = 4'b0000, O_IDF = 4'b0001, O_RUN = 4'b0100,
                         O_JF = 4'b1100, O_DN = 4'b0010, O_DNF = 4'b0011;

  typedef struct {
    logic       req;
    logic [1:0] sel;
    logic [6:0] fl;
    logic [9:0] off;
    logic [9:0] ja;
    logic [9:0] pc;
    logic [3:0] o;
    logic [3:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];

  prog_sequencer_if #(.PC_W(PC_W), .NUM_PROG(NPROG), .CNT_W(CNT_W)) bus ();

  prog_sequencer #(
    .PC_W(PC_W), .NUM_PROG(NPROG), .START_VECS(VECS), .STACK_DEPTH(2), .CNT_W(CNT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sif     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [1:0] sel, input logic [6:0] fl,
                       input logic [9:0] off, input logic [9:0] ja);
    bus.req          = req;
    bus.prog_sel     = sel;
    {bus.stall, bus.halt, bus.ret_en, bus.call_en, bus.jump_en,
     bus.branch_taken, bus.branch_skip} = fl;
    bus.br_off       = off;
    bus.jump_addr    = ja;
  endtask

  task automatic check_outs(input string tag, input logic [9:0] pc, input logic [3:0] o,
                            input logic [3:0] cnt);
    check({tag, " pc"},        32'(bus.pc), 32'(pc));
    check({tag, " read_jump"}, 32'(bus.read_jump), 32'(o[3]));
    check({tag, " busy"},      32'(bus.busy), 32'(o[2]));
    check({tag, " ack"},       32'(bus.ack), 32'(o[1]));
    check({tag, " fault"},     32'(bus.fault), 32'(o[0]));
    check({tag, " cycle_cnt"}, 32'(bus.cycle_cnt), 32'(cnt));
  endtask

  function automatic vec_t v(logic req, logic [1:0] sel, logic [6:0] fl, logic [9:0] off,
                             logic [9:0] ja, logic [9:0] pc, logic [3:0] o, logic [3:0] cnt);
    vec_t r;
    r.req = req; r.sel = sel; r.fl = fl; r.off = off; r.ja = ja;
    r.pc = pc; r.o = o; r.cnt = cnt;
    return r;
  endfunction

  initial begin
    // program 1: start, straight run (req dropped mid-run), jump, stalls, halt over ret, handshake
    tbl.push_back(v(1, 1, N,     0, 0,      10'h040, O_RUN, 0));
    tbl.push_back(v(0, 0, N,     0, 0,      10'h041, O_RUN, 1));
    tbl.push_back(v(0, 0, N,     0, 0,      10'h042, O_RUN, 2));
    tbl.push_back(v(0, 0, N,     0, 0,      10'h043, O_RUN, 3));
    tbl.push_back(v(0, 0, N,     0, 0,      10'h044, O_RUN, 4));
    tbl.push_back(v(0, 0, N,     0, 0,      10'h045, O_RUN, 5));
    tbl.push_back(v(0, 0, J,     0, 0,      10'h046, O_JF,  6));
    tbl.push_back(v(0, 0, C,     0, 10'h100, 10'h100, O_RUN, 7));
    tbl.push_back(v(0, 0, S | J, 0, 0,      10'h100, O_RUN, 8));
    tbl.push_back(v(0, 0, H | R, 0, 0,      10'h100, O_DN,  9));
    tbl.push_back(v(1, 0, N,     0, 0,      10'h100, O_DN,  9));
    tbl.push_back(v(0, 0, N,     0, 0,      10'h100, O_ID,  9));
    tbl.push_back(v(0, 0, N,     0, 0,      10'h100, O_ID,  9));
    // program 0: branch to 0x020, call with a stalled target fetch, skip, ret, ret on empty
    tbl.push_back(v(1, 0, N,     0,       0,       10'h010, O_RUN, 0));
    tbl.push_back(v(0, 0, B,     10'h010, 0,       10'h020, O_RUN, 1));
    tbl.push_back(v(0, 0, C,     0,       0,       10'h021, O_JF,  2));
    tbl.push_back(v(0, 0, S,     0,       10'h300, 10'h021, O_JF,  3));
    tbl.push_back(v(0, 0, N,     0,       10'h200, 10'h200, O_RUN, 4));
    tbl.push_back(v(0, 0, K,     0,       0,       10'h202, O_RUN, 5));
    tbl.push_back(v(0, 0, R,     0,       0,       10'h022, O_RUN, 6));
    tbl.push_back(v(0, 0, R,     0,       0,       10'h022, O_DNF, 7));
    tbl.push_back(v(0, 0, N,     0,       0,       10'h022, O_IDF, 7));
    // program 2: wrap past 0x3FF, negative branch, three nested calls on a 2-deep stack
    tbl.push_back(v(1, 2, N,     0,       0,       10'h3FE, O_RUN, 0));
    tbl.push_back(v(0, 0, N,     0,       0,       10'h3FF, O_RUN, 1));
    tbl.push_back(v(0, 0, N,     0,       0,       10'h000, O_RUN, 2));
    tbl.push_back(v(0, 0, K,     0,       0,       10'h002, O_RUN, 3));
    tbl.push_back(v(0, 0, B,     10'h003, 0,       10'h005, O_RUN, 4));
    tbl.push_back(v(0, 0, B,     10'h3F8, 0,       10'h3FD, O_RUN, 5));
    tbl.push_back(v(0, 0, C,     0,       0,       10'h3FE, O_JF,  6));
    tbl.push_back(v(0, 0, N,     0,       10'h050, 10'h050, O_RUN, 7));
    tbl.push_back(v(0, 0, C,     0,       0,       10'h051, O_JF,  8));
    tbl.push_back(v(0, 0, N,     0,       10'h060, 10'h060, O_RUN, 9));
    tbl.push_back(v(0, 0, C,     0,       0,       10'h060, O_DNF, 10));
    tbl.push_back(v(0, 0, N,     0,       0,       10'h060, O_IDF, 10));
    // out-of-range program index falls back to program 0, fault cleared on start
    tbl.push_back(v(1, 3, N,     0,       0,       10'h010, O_RUN, 0));

    drive(0, 0, N, 0, 0);
    #12;
    check_outs("reset", 10'h000, O_ID, 0);
    check("reset state", 32'(bus.dbg_state), 32'(prog_sequencer_pkg::IDLE));
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].req, tbl[i].sel, tbl[i].fl, tbl[i].off, tbl[i].ja);
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), tbl[i].pc, tbl[i].o, tbl[i].cnt);
    end

    // saturation: 20 more plain RUN cycles from pc=0x010, counter pins at 15
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(0, 0, N, 0, 0);
      @(posedge clk);
      #1;
      if (i == 14) check("cnt reaches max", 32'(bus.cycle_cnt), 32'd15);
    end
    check_outs("saturate", 10'h024, O_RUN, 15);

    // async reset while the jump target is being fetched
    @(negedge clk);
    drive(0, 0, J, 0, 10'h1AA);
    @(posedge clk);
    #1;
    check_outs("pre-reset jfetch", 10'h025, O_JF, 15);
    #2;
    reset_n = 1'b0;
    #1;
    check_outs("async reset", 10'h000, O_ID, 0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 0, N, 0, 0);
    @(posedge clk);
    #1;
    check_outs("post-reset idle", 10'h000, O_ID, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
